// File: rtl/png_ingress_fifo.sv
// FWFT ingress buffer feeding the hard_png decoder: payload plus ip/port tag per entry.
// Optional saturating drop counter enabled by defining PNG_BUF_DROP_CNT_EN.
module png_ingress_fifo #(
    parameter int DATA_W = 336,
    parameter int DEPTH  = 4,
    parameter int IP_W   = 32,
    parameter int PORT_W = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IP_W-1:0]   in_ip,
    input  logic [PORT_W-1:0] in_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IP_W-1:0]   out_ip,
    output logic [PORT_W-1:0] out_port,
    output logic [CNT_W-1:0]  level,
    output logic              overflow
`ifdef PNG_BUF_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_W + IP_W + PORT_W;

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   level_r;
    logic [CNT_W-1:0]   level_nxt_s;
    logic               overflow_r;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;
    logic [ENTRY_W-1:0] head_s;

    // Readiness is a function of the registered level only, so a pop never admits a push when full.
    assign in_ready_s  = (level_r < CNT_W'(DEPTH));
    assign out_valid_s = (level_r != {CNT_W{1'b0}});
    assign push_s      = in_valid & in_ready_s;
    assign pop_s       = out_valid_s & out_ready;
    assign drop_s      = in_valid & ~in_ready_s;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign level     = level_r;
    assign overflow  = overflow_r;
    assign head_s    = mem_r[rd_ptr_r];

    // Next occupancy from the push/pop pair.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + CNT_W'(1'b1);
            2'b01:   level_nxt_s = level_r - CNT_W'(1'b1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Head entry presented combinationally, zeroed while empty.
    always_comb begin
        out_data = {DATA_W{1'b0}};
        out_ip   = {IP_W{1'b0}};
        out_port = {PORT_W{1'b0}};
        if (out_valid_s) begin
            out_data = head_s[ENTRY_W-1 -: DATA_W];
            out_ip   = head_s[PORT_W +: IP_W];
            out_port = head_s[PORT_W-1:0];
        end else begin
            out_data = {DATA_W{1'b0}};
            out_ip   = {IP_W{1'b0}};
            out_port = {PORT_W{1'b0}};
        end
    end

    // Storage write; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= {in_data, in_ip, in_port};
        end
    end

    // Pointers, occupancy and sticky overflow; flush overrides push, pop and drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            level_r <= level_nxt_s;
            if (drop_s) overflow_r <= 1'b1;
        end
    end

`ifdef PNG_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of dropped writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= 16'h0000;
        end else if (flush) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_png_ingress_fifo.sv
// Randomized and directed bench for png_ingress_fifo against a queue-based reference model.
module tb_png_ingress_fifo;

    localparam int DW = 336;
    localparam int DEPTH = 4;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [31:0]    in_ip;
    logic [15:0]    in_port;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [31:0]    out_ip;
    logic [15:0]    out_port;
    logic [2:0]     level;
    logic           overflow;
`ifdef PNG_BUF_DROP_CNT_EN
    logic [15:0]    drop_cnt;
`endif

    png_ingress_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .IP_W(32), .PORT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ip(in_ip), .in_port(in_port),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ip(out_ip), .out_port(out_port),
        .level(level), .overflow(overflow)
`ifdef PNG_BUF_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [31:0]   ip;
        logic [15:0]   pt;
    } ent_t;

    ent_t q[$];
    logic m_ovf;
    int   m_dcnt;
    int   n_chk;
    int   n_fail;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 11; i++) r = {r[DW-33:0], $urandom()};
        return r;
    endfunction

    task automatic check_outputs();
        check_eq("level", level, q.size());
        check_eq("in_ready", in_ready, q.size() < DEPTH);
        check_eq("out_valid", out_valid, q.size() != 0);
        check_eq("out_data", out_data, (q.size() != 0) ? q[0].d : '0);
        check_eq("out_ip", out_ip, (q.size() != 0) ? q[0].ip : '0);
        check_eq("out_port", out_port, (q.size() != 0) ? q[0].pt : '0);
        check_eq("overflow", overflow, m_ovf);
`ifdef PNG_BUF_DROP_CNT_EN
        check_eq("drop_cnt", drop_cnt, m_dcnt);
`endif
    endtask

    // One clock: drive inputs, check state before the edge, then advance the model.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [31:0] ip,
                        input logic [15:0] pt, input logic ordy, input logic fl);
        int  sz;
        logic do_pop;
        logic do_push;
        ent_t e;
        in_valid = iv; in_data = d; in_ip = ip; in_port = pt; out_ready = ordy; flush = fl;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        sz = q.size();
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
            m_dcnt = 0;
        end else begin
            do_pop  = (sz != 0) && ordy;
            do_push = iv && (sz < DEPTH);
            if (iv && !(sz < DEPTH)) begin
                m_ovf = 1'b1;
                if (m_dcnt < 65535) m_dcnt++;
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.d = d; e.ip = ip; e.pt = pt;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 32'h0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; m_ovf = 1'b0; m_dcnt = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ip = 32'h0; in_port = 16'h0;
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill with tagged words, then drain in order.
        for (int i = 0; i < 4; i++)
            step(1'b1, DW'(8'hA1 + i), 32'h0A000001 + i, 16'(80 + i), 1'b0, 1'b0);
        check_eq("fill_level", level, 3'd4);
        check_eq("fill_ready", in_ready, 1'b0);

        // Drops at full.
        step(1'b1, DW'(8'hBB), 32'h0, 16'h0, 1'b0, 1'b0);
        step(1'b1, DW'(8'hBB), 32'h0, 16'h0, 1'b0, 1'b0);
        check_eq("drop_ovf", overflow, 1'b1);
        check_eq("drop_level", level, 3'd4);
`ifdef PNG_BUF_DROP_CNT_EN
        check_eq("drop_cnt2", drop_cnt, 16'd2);
`endif
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_order", out_data, DW'(8'hA1 + i));
            step(1'b0, '0, 32'h0, 16'h0, 1'b1, 1'b0);
        end
        step(1'b0, '0, 32'h0, 16'h0, 1'b0, 1'b1);

        // Simultaneous push+pop at level 2 across pointer wrap.
        step(1'b1, DW'(8'hB0), 32'h1, 16'h1, 1'b0, 1'b0);
        step(1'b1, DW'(8'hB1), 32'h2, 16'h2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, DW'(8'hC0 + i), 32'h100 + i, 16'(i), 1'b1, 1'b0);
        check_eq("simul_level", level, 3'd2);
        check_eq("simul_head", out_data, DW'(8'hC8));

        // Flush priority at level 3 with push and pop requested.
        step(1'b1, DW'(8'hD0), 32'h3, 16'h3, 1'b0, 1'b0);
        step(1'b1, DW'(8'hEE), 32'h4, 16'h4, 1'b1, 1'b1);
        check_eq("flush_level", level, 3'd0);
        check_eq("flush_ovf", overflow, 1'b0);

        // Push+pop on empty: push only.
        step(1'b1, DW'(8'h5A), 32'h5, 16'h5, 1'b1, 1'b0);
        check_eq("empty_pp_level", level, 3'd1);
        check_eq("empty_pp_data", out_data, DW'(8'h5A));
        idle();

        // Async reset mid-stream at level 3.
        for (int i = 0; i < 2; i++)
            step(1'b1, DW'(8'h70 + i), 32'h7, 16'h7, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_eq("rst_level", level, 3'd0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_data", out_data, '0);
        q.delete(); m_ovf = 1'b0; m_dcnt = 0;
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 6, rnd_word(), $urandom(), 16'($urandom()),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
